// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage HI/LO op, multiplier, divider and HI/LO write bundle
//
// Carries the signals between EX decode, the mul/div units and the HI/LO
// write port. The slave modport is the controller side. The master modport
// is the surrounding EX stage plus the multiplier and divider units.
//   op_valid/op_sel/src_a/src_b : decoded HI/LO op and rs/rt operand values
//   ex_hold/flush                : later-stage stall and kill of the in-flight op
//   stallreq                     : stop IF..EX while the result is pending
//   mul_*                        : multiplier operands, signedness and product
//   div_*                        : divider start/annul/operands/ready/result
//   hi_we/lo_we/hi_wdata/lo_wdata: registered HI/LO write port
//   busy                         : controller is not idle
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [5:0]  op_sel;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        ex_hold;
  logic        flush;
  logic        stallreq;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_ready;
  logic [63:0] div_result;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        busy;

  modport slave (
    input  op_valid, op_sel, src_a, src_b, ex_hold, flush,
    input  mul_result, div_ready, div_result,
    output stallreq, mul_signed, mul_a, mul_b,
    output div_start, div_signed, div_annul, div_a, div_b,
    output hi_we, lo_we, hi_wdata, lo_wdata, busy
  );

  modport master (
    output op_valid, op_sel, src_a, src_b, ex_hold, flush,
    output mul_result, div_ready, div_result,
    input  stallreq, mul_signed, mul_a, mul_b,
    input  div_start, div_signed, div_annul, div_a, div_b,
    input  hi_we, lo_we, hi_wdata, lo_wdata, busy
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencing controller for EX
//
// Accepts one decoded HI/LO op (div, divu, mult, multu, mtlo, mthi) and
// launches the clocked multiplier or the iterative divider. It holds the
// pipeline via stallreq until the result exists and then issues a one-cycle
// registered HI/LO write.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : muldiv_ctrl_if.slave (op decode, mul/div unit handshakes, HI/LO write)
// Parameter:
//   MUL_CYCLES : fixed multiplier latency, 1..15
// Optional feature macro:
//   DIV_ZERO_FAST_EN : a divide with a zero divisor bypasses the divider and
//                      commits HI=src_a, LO=32'hFFFF_FFFF after a 1-cycle stall
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_ctrl_if.slave   bus
);
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] opa, opb;
  logic        sgn;
  logic        hi_we_q, lo_we_q;
  logic [31:0] hi_q, lo_q;

  logic accept, is_mul, is_div, div_zero, mul_last, div_done;
  logic stallreq_c, div_start_c, div_annul_c;

  // op_sel is one-hot {div, divu, mult, multu, mtlo, mthi}
  always_comb begin
    accept = (state == IDLE) && bus.op_valid && !bus.flush && !rst;
    is_mul = bus.op_sel[3] | bus.op_sel[2];
    is_div = bus.op_sel[5] | bus.op_sel[4];
`ifdef DIV_ZERO_FAST_EN
    div_zero = is_div && (bus.src_b == 32'd0);
`else
    div_zero = 1'b0;
`endif
    // flush beats a result arriving in the same cycle
    mul_last = (state == MUL) && (cnt == 4'd1) && !bus.flush;
    div_done = (state == DIV) && bus.div_ready && !bus.flush;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_nxt = MUL;
        else if (accept && is_div) state_nxt = div_zero ? DONE : DIV;
      end
      MUL:     if (cnt == 4'd1)    state_nxt = DONE;
      DIV:     if (bus.div_ready)  state_nxt = DONE;
      DONE:    if (!bus.ex_hold)   state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_comb begin
    stallreq_c  = NO_STOP;
    div_start_c = 1'b0;
    div_annul_c = 1'b0;
    case (state)
      IDLE: if (accept && (is_mul || is_div)) stallreq_c = STOP;
      MUL:  stallreq_c = STOP;
      DIV: begin
        stallreq_c  = STOP;
        div_start_c = !bus.flush;
        div_annul_c = bus.flush;
      end
      default: ;
    endcase
  end

  // Operand latch, latency counter and the registered HI/LO write port.
  // Strobes default low so each write lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      opa     <= 32'd0;
      opb     <= 32'd0;
      sgn     <= 1'b0;
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      if (state == MUL) cnt <= cnt - 4'd1;
      if (accept && (is_mul || is_div)) begin
        opa <= bus.src_a;
        opb <= bus.src_b;
        sgn <= bus.op_sel[5] | bus.op_sel[3];
        if (is_mul) cnt <= 4'(MUL_CYCLES);
      end
      if (accept && bus.op_sel[0]) begin
        hi_we_q <= 1'b1;
        hi_q    <= bus.src_a;
      end
      if (accept && bus.op_sel[1]) begin
        lo_we_q <= 1'b1;
        lo_q    <= bus.src_a;
      end
      if (accept && div_zero) begin
        hi_we_q <= 1'b1;
        lo_we_q <= 1'b1;
        hi_q    <= bus.src_a;
        lo_q    <= 32'hFFFF_FFFF;
      end
      if (mul_last) begin
        hi_we_q      <= 1'b1;
        lo_we_q      <= 1'b1;
        {hi_q, lo_q} <= bus.mul_result;
      end
      if (div_done) begin
        hi_we_q      <= 1'b1;
        lo_we_q      <= 1'b1;
        {hi_q, lo_q} <= bus.div_result;
      end
    end
  end

  assign bus.stallreq   = stallreq_c;
  assign bus.div_start  = div_start_c;
  assign bus.div_annul  = div_annul_c;
  assign bus.busy       = (state != IDLE);
  assign bus.mul_signed = sgn;
  assign bus.mul_a      = opa;
  assign bus.mul_b      = opb;
  assign bus.div_signed = sgn;
  assign bus.div_a      = opa;
  assign bus.div_b      = opb;
  assign bus.hi_we      = hi_we_q;
  assign bus.lo_we      = lo_we_q;
  assign bus.hi_wdata   = hi_q;
  assign bus.lo_wdata   = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl with random ops and a reference model
module tb_muldiv_ctrl;
  localparam int MC = 2;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [5:0] OP_DIV   = 6'b100000;
  localparam logic [5:0] OP_DIVU  = 6'b010000;
  localparam logic [5:0] OP_MULT  = 6'b001000;
  localparam logic [5:0] OP_MULTU = 6'b000100;
  localparam logic [5:0] OP_MTLO  = 6'b000010;
  localparam logic [5:0] OP_MTHI  = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   div_lat = 1;
  int   dcnt = 0;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_CYCLES(MC)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // {remainder, quotient}; zero divisor yields {dividend, all ones}
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Multiplier unit: one register stage behind the operands
  always @(posedge clk) bus.mul_result <= mul_ref(bus.mul_a, bus.mul_b, bus.mul_signed);

  // Divider unit: ready pulses after div_lat cycles of div_start
  always @(posedge clk) begin
    if (rst || !bus.div_start || bus.div_annul || bus.div_ready) begin
      dcnt <= 0;
      bus.div_ready <= 1'b0;
    end else begin
      dcnt <= dcnt + 1;
      if (dcnt == div_lat - 1) begin
        bus.div_ready  <= 1'b1;
        bus.div_result <= div_ref(bus.div_a, bus.div_b, bus.div_signed);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op to EX at cycle 0 and play the EX stage: the op stays valid
  // until it advances (no stall and no hold) or is flushed.
  task automatic run_op(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold, input int flush_at);
    int n_stall, n_start, n_annul, n_hi, n_lo, hi_cyc, lo_cyc, rdy_cyc, hold_left, idle_run;
    logic [31:0] hi_v, lo_v;
    logic [63:0] r;
    logic busy_fl, done, adv, is_mul, is_div, fz;
    n_stall = 0; n_start = 0; n_annul = 0; n_hi = 0; n_lo = 0;
    hi_cyc = -1; lo_cyc = -1; rdy_cyc = -1; hold_left = 0; idle_run = 0;
    hi_v = 0; lo_v = 0; busy_fl = 1'b1; done = 1'b0;
    div_lat = lat;
    bus.op_valid = 1'b1; bus.op_sel = sel; bus.src_a = a; bus.src_b = b;
    for (int c = 0; c < 300 && !done; c++) begin
      if (bus.hi_we) begin n_hi++; hi_v = bus.hi_wdata; hi_cyc = c; end
      if (bus.lo_we) begin n_lo++; lo_v = bus.lo_wdata; lo_cyc = c; end
      if ((bus.hi_we || bus.lo_we) && (n_hi + n_lo) <= 2) hold_left = hold;
      bus.ex_hold = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      bus.flush = (c == flush_at);
      if (flush_at >= 0 && c == flush_at + 1) busy_fl = bus.busy;
      if (bus.div_ready) rdy_cyc = c;
      #1;
      if (bus.stallreq) n_stall++;
      if (bus.div_start) n_start++;
      if (bus.div_annul) n_annul++;
      adv = bus.op_valid && ((!bus.stallreq && !bus.ex_hold) || bus.flush);
      if (!bus.op_valid && !bus.busy) idle_run++;
      else idle_run = 0;
      done = (idle_run >= 3);
      tick();
      if (adv) bus.op_valid = 1'b0;
    end
    bus.op_valid = 1'b0; bus.ex_hold = 1'b0; bus.flush = 1'b0;
    check("budget", done, 1);
    is_mul = sel[3] | sel[2];
    is_div = sel[5] | sel[4];
    fz = FAST && is_div && (b == 32'd0);
    if (flush_at >= 0) begin
      check("flush_annul", n_annul, 1);
      check("flush_busy", busy_fl, 0);
      check("flush_hi_we", n_hi, 0);
      check("flush_lo_we", n_lo, 0);
    end else if (is_mul) begin
      r = mul_ref(a, b, sel[3]);
      check("mul_stall", n_stall, MC + 1);
      check("mul_strobe_cyc", hi_cyc, MC + 1);
      check("mul_n_hi", n_hi, 1);
      check("mul_n_lo", n_lo, 1);
      check("mul_hi", hi_v, r[63:32]);
      check("mul_lo", lo_v, r[31:0]);
      check("mul_start", n_start, 0);
    end else if (is_div) begin
      r = div_ref(a, b, sel[5]);
      if (fz) begin
        check("dz_stall", n_stall, 1);
        check("dz_strobe_cyc", hi_cyc, 1);
        check("dz_start", n_start, 0);
      end else begin
        check("div_ready_cyc", rdy_cyc, lat + 1);
        check("div_stall", n_stall, rdy_cyc + 1);
        check("div_strobe_cyc", hi_cyc, rdy_cyc + 1);
        check("div_start", n_start, rdy_cyc);
      end
      check("div_n_hi", n_hi, 1);
      check("div_n_lo", n_lo, 1);
      check("div_hi", hi_v, r[63:32]);
      check("div_lo", lo_v, r[31:0]);
    end else begin
      check("mt_stall", n_stall, 0);
      check("mt_strobe_cyc", sel[0] ? hi_cyc : lo_cyc, 1);
      check("mt_n_hi", n_hi, sel[0] ? 1 : 0);
      check("mt_n_lo", n_lo, sel[1] ? 1 : 0);
      check("mt_data", sel[0] ? hi_v : lo_v, a);
    end
    if (flush_at < 0) check("no_annul", n_annul, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] sel;
    logic [31:0] a, b;
    int n;
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op_sel = 6'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
    bus.ex_hold = 1'b0; bus.flush = 1'b0;
    repeat (3) tick();
    check("rst_stallreq", bus.stallreq, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_hi_we", bus.hi_we, 0);
    check("rst_lo_we", bus.lo_we, 0);
    check("rst_hi_wdata", bus.hi_wdata, 0);
    check("rst_lo_wdata", bus.lo_wdata, 0);
    check("rst_div_start", bus.div_start, 0);
    rst = 1'b0;
    tick();

    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1, 0, -1);
    run_op(OP_DIVU,  32'd100, 32'd7, 32, 0, -1);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 5, 0, -1);
    run_op(OP_MTHI,  32'h1234_5678, 32'd0, 1, 0, -1);
    run_op(OP_MTLO,  32'h0BAD_CAFE, 32'd0, 1, 0, -1);
    run_op(OP_DIVU,  32'd1000, 32'd3, 20, 0, 10);
    run_op(OP_MULTU, 32'd5, 32'd6, 1, 0, -1);
    run_op(OP_MULT,  32'h8000_0000, 32'h7FFF_FFFF, 1, 3, -1);
    run_op(OP_DIVU,  32'd9, 32'd0, 4, 0, -1);
    run_op(OP_MTHI,  32'hA5A5_0001, 32'd0, 1, 0, -1);
    run_op(OP_MTHI,  32'hA5A5_0002, 32'd0, 1, 0, -1);

    for (int i = 0; i < 40; i++) begin
      sel = 6'b000001 << $urandom_range(0, 5);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50)));
      run_op(sel, a, b, $urandom_range(1, 40), $urandom_range(0, 3), -1);
    end

    // reset in the middle of a multiply clears state and suppresses the write
    bus.op_valid = 1'b1; bus.op_sel = OP_MULT; bus.src_a = 32'd7; bus.src_b = 32'd9;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", bus.busy, 0);
    check("midrst_hi_wdata", bus.hi_wdata, 0);
    check("midrst_lo_wdata", bus.lo_wdata, 0);
    rst = 1'b0;
    bus.op_valid = 1'b0;
    n = 0;
    repeat (5) begin
      tick();
      if (bus.hi_we || bus.lo_we) n++;
    end
    check("midrst_strobes", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the EX-stage multiply/divide resources. It accepts one decoded HI/LO operation (div, divu, mult, multu, mthi, mtlo) and launches the clocked multiplier or iterative divider. It holds the pipeline through `stallreq` until the result exists, then issues registered HI/LO write strobes with data. It sits between the EX-stage decode fields and the `mul`/`div` units and replaces ad-hoc start/stall logic in EX.

## Interface
- `MUL_CYCLES`, 2: fixed multiplier latency in cycles, range 1–15.
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: EX holds a valid HI/LO op this cycle.
- `op_sel` in 6: one-hot `{div, divu, mult, multu, mtlo, mthi}`. More than one bit set is illegal.
- `src_a`, `src_b` in 32: rs and rt operand values.
- `ex_hold` in 1: a later stage is stalling, so the EX instruction will not advance this cycle.
- `flush` in 1: kill the in-flight op.
- `stallreq` out 1: request the pipeline to stop IF–EX (`Stop`/`NoStop` encoding).
- `mul_signed` out 1: signed-multiply select to `mul`.
- `mul_a`, `mul_b` out 32: multiplier operands.
- `mul_result` in 64: multiplier product.
- `div_start` out 1: divider start, held high until `div_ready`.
- `div_signed` out 1: signed-divide select.
- `div_annul` out 1: abort the divider.
- `div_a`, `div_b` out 32: dividend and divisor.
- `div_ready` in 1: divider result valid.
- `div_result` in 64: `{remainder, quotient}`.
- `hi_we`, `lo_we` out 1: HI/LO write strobes (registered).
- `hi_wdata`, `lo_wdata` out 32: HI/LO write data (registered).
- `busy` out 1: FSM is not IDLE.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset puts the FSM in IDLE and zeroes every registered output and counter.
- IDLE accepts an op when `op_valid` is high and `flush` is low.
  - mult/multu: latch operands and signedness, load the counter with `MUL_CYCLES`, go to MUL.
  - div/divu: latch operands and signedness, go to DIV.
  - mthi: register `hi_we`=1 and `hi_wdata`=`src_a` for the next cycle. FSM stays in IDLE and there is no stall.
  - mtlo: same as mthi, but writes LO.
- MUL decrements the counter every cycle. When the count is 1, capture `mul_result` into `{hi_wdata, lo_wdata}` and go to DONE.
- DIV holds `div_start` high with the latched operands. On the cycle `div_ready` is high, capture `div_result[63:32]`→HI and `div_result[31:0]`→LO, drop `div_start`, and go to DONE.
- DONE drives `hi_we`=`lo_we`=1 on exactly one cycle: the first cycle in DONE.
  - Stays in DONE while `ex_hold` is high, with strobes low after the first cycle.
  - Goes to IDLE when `ex_hold` is low. It never re-accepts the same instruction.
- `stallreq` is combinational:
  - High in IDLE when a mult/multu/div/divu is being accepted.
  - High in MUL and in DIV.
  - Low in DONE and for mthi/mtlo.
- `flush` in any state:
  - Next state is IDLE, and no strobes are issued.
  - `div_annul`=1 for that cycle if the FSM is in DIV.
  - `flush` overrides `div_ready` arriving in the same cycle.
- `rst` mid-operation: same effect as `flush`, plus all registers are cleared. `div_annul` is not required.
- Multiplier operands and signedness are held stable throughout MUL.

## Timing
- Accept at cycle T:
  - mult/multu: HI/LO strobes at cycle T+`MUL_CYCLES`+1.
  - div/divu: strobes 1 cycle after the `div_ready` cycle.
  - mthi/mtlo: strobe at T+1.
- `stallreq` is high from T through the last MUL/DIV cycle, and low in the strobe cycle so EX advances.
- Back-to-back ops: a new op may be accepted in the cycle after DONE exits. An mthi/mtlo may be accepted in the cycle after another mthi/mtlo.

## Configuration
- `DIV_ZERO_FAST_EN`
  - Defined: div/divu with `src_b`==0 skips DIV. It goes straight to DONE with HI=`src_a` and LO=32'hFFFF_FFFF. There is no `div_start` and a 1-cycle stall.
  - Undefined: a zero divisor goes through the divider like any other divide, and its output is committed unchanged.

## Test plan
- mult with `src_a`=32'hFFFF_FFFE and `src_b`=3, `MUL_CYCLES`=2 -> `stallreq` high for 3 cycles, then HI=32'hFFFF_FFFF and LO=32'hFFFF_FFFA with strobes for 1 cycle.
- divu 100/7 with a model divider, ready after 33 cycles -> `div_start` high until ready, then HI=2 and LO=14.
- div −7/2 -> HI=32'hFFFF_FFFF (−1) and LO=32'hFFFF_FFFD (−3).
- mthi 32'h1234_5678 -> no stall, `hi_we` only at T+1 with `hi_wdata`=32'h1234_5678.
- `flush` at DIV cycle 10 -> `div_annul` pulse, IDLE next cycle, no strobes. A following multu 5×6 -> LO=30.
- `ex_hold` high for 3 cycles in DONE -> exactly one strobe, no re-accept.
- With `DIV_ZERO_FAST_EN`, divu 9/0 -> HI=9 and LO=32'hFFFF_FFFF with no `div_start`.
